// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch front end for the FD boundary of the pipelined core.
// Owns the PC, issues req/gnt fetches to instruction memory, buffers the
// returned words in a small circular FIFO and presents {PC, instruction} to
// decode with valid/stall flow control. An execute-stage redirect flushes the
// buffer and marks every fetch still in flight for discard.
//
// Ports
//   CLK          in   1   clock, rising edge
//   RESET        in   1   asynchronous, active-low reset
//   REDIRECT     in   1   execute resolved a taken jump/branch this cycle
//   REDIRECT_PC  in   32  redirect target (bits [1:0] ignored)
//   STALL        in   1   decode cannot accept the FD entry this cycle
//   IMEM_REQ     out  1   fetch request valid
//   IMEM_ADDR    out  32  fetch byte address, word aligned
//   IMEM_GNT     in   1   request accepted this cycle
//   IMEM_RVALID  in   1   in-order response valid
//   IMEM_RDATA   in   32  response instruction word
//   FD_VALID     out  1   FD_PC/FD_IR hold a valid instruction
//   FD_PC        out  32  PC of the head instruction (0 when invalid)
//   FD_IR        out  32  head instruction word (NOP_INST when invalid)
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2,
  parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  input  logic        STALL,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_GNT,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  output logic        FD_VALID,
  output logic [31:0] FD_PC,
  output logic [31:0] FD_IR
);

  localparam int CW  = $clog2(BUF_DEPTH + 1);
  localparam int CW1 = CW + 1;
  localparam int PW  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  // Circular pointer advance; BUF_DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(BUF_DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  // State registers
  logic [31:0]   pc_q,      pc_d;
  logic [CW-1:0] occ_q,     occ_d;      // valid entries in the buffer
  logic [CW-1:0] outst_q,   outst_d;    // granted fetches awaiting a response
  logic [CW-1:0] disc_q,    disc_d;     // oldest outstanding responses to drop
  logic [PW-1:0] wr_ptr_q,  wr_ptr_d;
  logic [PW-1:0] rd_ptr_q,  rd_ptr_d;
  logic [PW-1:0] pq_wr_q,   pq_wr_d;    // PC queue of outstanding fetches
  logic [PW-1:0] pq_rd_q,   pq_rd_d;

  // Storage arrays
  logic [31:0] buf_pc_q [BUF_DEPTH];
  logic [31:0] buf_ir_q [BUF_DEPTH];
  logic [31:0] pq_pc_q  [BUF_DEPTH];

  // Per-cycle events
  logic [CW1-1:0] inflight;
  logic           issue;
  logic           resp;
  logic           keep;
  logic           pop;

  // Issue is gated on buffered + outstanding, so every granted fetch is
  // guaranteed a buffer slot when its response returns.
  assign inflight  = {1'b0, occ_q} + {1'b0, outst_q};
  // RESET gates the request so it is low while reset is held and rises in
  // the very first cycle after release.
  assign IMEM_REQ  = RESET && (inflight < CW1'(BUF_DEPTH));
  assign IMEM_ADDR = pc_q;

  assign issue = IMEM_REQ && IMEM_GNT;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp  = IMEM_RVALID && (outst_q != '0);
  assign keep  = resp && (disc_q == '0) && !REDIRECT;

  assign FD_VALID = (occ_q != '0);
  assign pop      = FD_VALID && !STALL && !REDIRECT;

  assign FD_PC = FD_VALID ? buf_pc_q[rd_ptr_q] : 32'h0;
  assign FD_IR = FD_VALID ? buf_ir_q[rd_ptr_q] : NOP_INST;

  // Low address bits of the redirect target are forced to zero.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^REDIRECT_PC[1:0];

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    pc_d     = pc_q;
    occ_d    = occ_q;
    disc_d   = disc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pq_wr_d  = pq_wr_q;
    pq_rd_d  = pq_rd_q;
    outst_d  = outst_q + CW'(issue) - CW'(resp);

    if (issue) begin
      pc_d    = pc_q + 32'd4;
      pq_wr_d = ptr_inc(pq_wr_q);
    end
    if (resp) begin
      pq_rd_d = ptr_inc(pq_rd_q);
    end
    if (resp && (disc_q != '0)) begin
      disc_d = disc_q - CW'(1);
    end

    if (keep) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    occ_d = occ_q + CW'(keep) - CW'(pop);

    // Redirect overrides everything: flush the buffer and mark every fetch
    // still in flight, including one granted this cycle, for discard.
    if (REDIRECT) begin
      pc_d     = {REDIRECT_PC[31:2], 2'b00};
      occ_d    = '0;
      rd_ptr_d = wr_ptr_q;
      wr_ptr_d = wr_ptr_q;
      disc_d   = outst_d;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pc_q     <= RESET_PC;
      occ_q    <= '0;
      outst_q  <= '0;
      disc_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      pq_wr_q  <= '0;
      pq_rd_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values regardless of statement order.
      pc_q     <= pc_d;
      occ_q    <= occ_d;
      outst_q  <= outst_d;
      disc_q   <= disc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      pq_wr_q  <= pq_wr_d;
      pq_rd_q  <= pq_rd_d;
    end
  end

  // NOTE: the storage arrays carry no reset; an entry is only read when the
  // occupancy/outstanding counters say it was written.
  always_ff @(posedge CLK) begin
    if (issue) begin
      pq_pc_q[pq_wr_q] <= pc_q;
    end
    if (keep) begin
      buf_pc_q[wr_ptr_q] <= pq_pc_q[pq_rd_q];
      buf_ir_q[wr_ptr_q] <= IMEM_RDATA;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. A queue-based reference model (buffered
// entries and in-flight fetches with discard flags) predicts every output on
// every falling edge; literal expectations at key points pin the model.
// A second instance with RESET_PC = 0xFFFF_FFF8 shares all inputs to show
// the PC wrap.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n, redirect, stall, gnt, rvalid;
  logic [31:0] redirect_pc, rdata;
  logic        imem_req, fd_valid;
  logic [31:0] imem_addr, fd_pc, fd_ir;
  logic        hi_req, hi_valid;
  logic [31:0] hi_addr, hi_pc, hi_ir;

  fetch_unit u_dut (
    .CLK(clk), .RESET(rst_n), .REDIRECT(redirect), .REDIRECT_PC(redirect_pc),
    .STALL(stall), .IMEM_REQ(imem_req), .IMEM_ADDR(imem_addr), .IMEM_GNT(gnt),
    .IMEM_RVALID(rvalid), .IMEM_RDATA(rdata), .FD_VALID(fd_valid),
    .FD_PC(fd_pc), .FD_IR(fd_ir)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_dut_hi (
    .CLK(clk), .RESET(rst_n), .REDIRECT(redirect), .REDIRECT_PC(redirect_pc),
    .STALL(stall), .IMEM_REQ(hi_req), .IMEM_ADDR(hi_addr), .IMEM_GNT(gnt),
    .IMEM_RVALID(rvalid), .IMEM_RDATA(rdata), .FD_VALID(hi_valid),
    .FD_PC(hi_pc), .FD_IR(hi_ir)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] addr);
    return addr ^ 32'hDEAD_0000;
  endfunction

  // Instruction memory: in-order, one response per cycle, 1-cycle minimum.
  logic [31:0] pend[$];
  bit          resp_en;
  always @(posedge clk) begin
    if (rst_n && imem_req && gnt) pend.push_back(imem_addr);
    #1;
    if (resp_en && pend.size() > 0) begin
      rvalid = 1'b1;
      rdata  = word_of(pend.pop_front());
    end else begin
      rvalid = 1'b0;
      rdata  = 32'h0;
    end
  end

  // First three granted addresses of the high-RESET_PC instance.
  logic [31:0] hi_grants[$];
  always @(posedge clk) begin
    if (rst_n && hi_req && gnt && hi_grants.size() < 3) hi_grants.push_back(hi_addr);
  end

  // Reference model
  typedef struct { logic [31:0] pc; logic [31:0] ir; } fd_ent_t;
  typedef struct { logic [31:0] pc; bit disc; } fl_ent_t;

  fd_ent_t     m_fd[$];
  fl_ent_t     m_fl[$];
  logic [31:0] m_pc;
  fl_ent_t     m_tmp;
  bit          m_issue, m_pop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 32'h0;
      m_fd.delete();
      m_fl.delete();
    end else begin
      m_issue = (m_fd.size() + m_fl.size() < DEPTH) && gnt;
      m_pop   = (m_fd.size() > 0) && !stall && !redirect;
      if (m_pop) void'(m_fd.pop_front());
      if (rvalid && m_fl.size() > 0) begin
        m_tmp = m_fl.pop_front();
        if (!m_tmp.disc && !redirect) m_fd.push_back('{m_tmp.pc, rdata});
      end
      if (m_issue) begin
        m_fl.push_back('{m_pc, 1'b0});
        m_pc = m_pc + 32'd4;
      end
      if (redirect) begin
        m_fd.delete();
        foreach (m_fl[i]) m_fl[i].disc = 1'b1;
        m_pc = {redirect_pc[31:2], 2'b00};
      end
    end
  end

  // Per-cycle compare and record of consumed instructions.
  fd_ent_t consumed[$];
  always @(negedge clk) begin
    logic        e_req, e_valid;
    logic [31:0] e_pc, e_ir;
    e_req   = rst_n && (m_fd.size() + m_fl.size() < DEPTH);
    e_valid = (m_fd.size() > 0);
    e_pc    = 32'h0;
    e_ir    = NOP;
    if (e_valid) begin
      e_pc = m_fd[0].pc;
      e_ir = m_fd[0].ir;
    end
    check("imem_req",  32'(imem_req), 32'(e_req));
    check("imem_addr", imem_addr,     m_pc);
    check("fd_valid",  32'(fd_valid), 32'(e_valid));
    check("fd_pc",     fd_pc,         e_pc);
    check("fd_ir",     fd_ir,         e_ir);
    if (rst_n && fd_valid && !stall && !redirect) consumed.push_back('{fd_pc, fd_ir});
  end

  function automatic logic [31:0] c_pc(input int i);
    if (i < consumed.size()) return consumed[i].pc;
    return 32'hBAD0_BAD0;
  endfunction

  function automatic logic [31:0] c_ir(input int i);
    if (i < consumed.size()) return consumed[i].ir;
    return 32'hBAD0_BAD0;
  endfunction

  function automatic logic [31:0] hi_at(input int i);
    if (i < hi_grants.size()) return hi_grants[i];
    return 32'hBAD0_BAD0;
  endfunction

  initial begin
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
    gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0; resp_en = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    #2;
    check("rst_req",   32'(imem_req), 32'd0);
    check("rst_addr",  imem_addr,     32'h0);
    check("rst_valid", 32'(fd_valid), 32'd0);
    check("rst_fd_pc", fd_pc,         32'h0);
    check("rst_fd_ir", fd_ir,         32'h0000_0013);

    // Streaming fetch from RESET_PC
    rst_n = 1'b1; gnt = 1'b1;
    #1;
    check("first_req",  32'(imem_req), 32'd1);
    check("first_addr", imem_addr,     32'h0);

    // Stall while 0x8 is at the head
    repeat (5) @(posedge clk);
    #2 stall = 1'b1;
    @(negedge clk);
    check("stall_fd_valid", 32'(fd_valid), 32'd1);
    check("stall_fd_pc",    fd_pc,         32'h8);
    repeat (5) @(posedge clk);
    #2;
    check("stall_req_off",   32'(imem_req), 32'd0);
    check("stall_fd_pc_end", fd_pc,         32'h8);
    stall = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    check("seq_pc0", c_pc(0), 32'h0);
    check("seq_pc1", c_pc(1), 32'h4);
    check("seq_pc2", c_pc(2), 32'h8);
    check("seq_pc3", c_pc(3), 32'hC);
    check("seq_pc4", c_pc(4), 32'h10);
    check("seq_ir0", c_ir(0), 32'hDEAD_0000);
    check("seq_ir4", c_ir(4), 32'hDEAD_0010);

    // Redirect to 0x103 with two fetches in flight
    resp_en = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    consumed.delete();
    @(posedge clk);
    #2;
    redirect = 1'b0; resp_en = 1'b1;
    check("redir_addr",  imem_addr,     32'h100);
    check("redir_valid", 32'(fd_valid), 32'd0);
    repeat (10) @(posedge clk);
    #2;
    check("redir_pc0", c_pc(0), 32'h100);
    check("redir_ir0", c_ir(0), 32'hDEAD_0100);
    check("redir_pc1", c_pc(1), 32'h104);

    // Ungranted request holds its address
    consumed.delete();
    redirect = 1'b1; redirect_pc = 32'h0000_000C; gnt = 1'b0;
    @(posedge clk);
    #2 redirect = 1'b0;
    check("nognt_addr1", imem_addr, 32'hC);
    @(posedge clk);
    #2 check("nognt_addr2", imem_addr, 32'hC);
    @(posedge clk);
    #2 check("nognt_addr3", imem_addr, 32'hC);
    gnt = 1'b1;
    @(posedge clk);
    #2 check("gnt_addr", imem_addr, 32'h10);
    repeat (6) @(posedge clk);
    #2;
    check("gnt_pc0", c_pc(0), 32'hC);
    check("gnt_pc1", c_pc(1), 32'h10);

    // Reset mid-stream with fetches outstanding
    resp_en = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0; gnt = 1'b0;
    #1;
    check("mid_rst_req",   32'(imem_req), 32'd0);
    check("mid_rst_addr",  imem_addr,     32'h0);
    check("mid_rst_valid", 32'(fd_valid), 32'd0);
    check("mid_rst_pc",    fd_pc,         32'h0);
    check("mid_rst_ir",    fd_ir,         32'h0000_0013);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1; resp_en = 1'b1;
    consumed.delete();
    #1;
    check("rel_req",  32'(imem_req), 32'd1);
    check("rel_addr", imem_addr,     32'h0);
    repeat (4) @(posedge clk);
    #2;
    check("stale_valid", 32'(fd_valid), 32'd0);
    check("stale_addr",  imem_addr,     32'h0);
    gnt = 1'b1;
    repeat (8) @(posedge clk);
    #2;
    check("rerun_pc0", c_pc(0), 32'h0);
    check("rerun_ir0", c_ir(0), 32'hDEAD_0000);
    check("rerun_pc1", c_pc(1), 32'h4);

    // PC wrap on the high-RESET_PC instance
    check("wrap_addr0", hi_at(0), 32'hFFFF_FFF8);
    check("wrap_addr1", hi_at(1), 32'hFFFF_FFFC);
    check("wrap_addr2", hi_at(2), 32'h0000_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
